one_unit_reduce: RTL and testbench

- Consumer of the outer-product multiplier's output stream for one ICA unit, performing the reverse operation (reduction).
- Per sample, rebuilds the projection y = w^T z from the diagonal products z_i*w_i, then forms z_i*y.
- Averages z*y over NSAMP accepted samples and presents E{z*y} as a Q13 vector to the weight-update stage.
- Sits directly downstream of the multiplier stage in the one-unit datapath.

---
 rtl/ica_fx_pkg.sv | 38 +++
 rtl/one_unit_reduce_lane.sv | 47 ++++
 rtl/one_unit_reduce.sv | 186 ++++++++++++++++++
 tb/tb_one_unit_reduce.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ica_fx_pkg.sv
// Shared fixed-point definitions for the one-unit ICA datapath.
//   DW / FRAC / Q13_ONE : signed Q13 sample format (1.0 = 8192).
//   PROD_HI / PROD_LO   : bit range of a DW x DW product that holds the Q13 result.
//   red_state_t         : state encoding of the reduction controller.
//   narrow_dw / ovf_dw  : narrowing a wide signed value to DW bits (saturate or wrap).
package ica_fx_pkg;

  localparam int DW      = 26;
  localparam int FRAC    = 13;
  localparam int Q13_ONE = 8192;
  localparam int PROD_HI = 38;
  localparam int PROD_LO = 13;

  localparam logic signed [63:0] DW_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam logic signed [63:0] DW_MIN = -(64'sd1 <<< (DW - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DIV   = 2'd3
  } red_state_t;

  // True when v does not fit in a signed DW-bit value.
  function automatic logic ovf_dw(input logic signed [63:0] v);
    return (v > DW_MAX) || (v < DW_MIN);
  endfunction

  // Narrow v to DW bits: clamp to the DW range when sat is set, otherwise
  // keep the low DW bits (two's-complement wrap).
  function automatic logic signed [DW-1:0] narrow_dw(input logic signed [63:0] v,
                                                     input logic sat);
    if (sat && (v > DW_MAX)) return DW_MAX[DW-1:0];
    if (sat && (v < DW_MIN)) return DW_MIN[DW-1:0];
    return v[DW-1:0];
  endfunction

endpackage

// File: rtl/one_unit_reduce_lane.sv
// One lane of the reduction: multiplies the registered sample z_i by the
// projection y, rescales the product back to Q13 and accumulates it.
// Ports:
//   clk_red, rstn_red : clock, synchronous active-low reset
//   clr               : clear the accumulator (start of a run)
//   en                : stage-1 data valid, accumulate this cycle
//   z, y              : signed Q13 operands from stage 1
//   acc               : signed ACCW-bit running sum of Q13 products
module one_unit_reduce_lane
  import ica_fx_pkg::*;
#(
  parameter int DW   = 26,
  parameter int ACCW = 48
) (
  input  logic                   clk_red,
  input  logic                   rstn_red,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   z,
  input  logic signed [DW-1:0]   y,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [DW-1:0]   prod_q13;
  logic signed [ACCW-1:0] prod_ext;
  logic                   unused_prod;

  assign prod     = z * y;
  // Q13 x Q13 = Q26; dropping FRAC low bits returns to Q13. The top bits are
  // discarded on purpose: the product of two in-range samples is kept to DW.
  assign prod_q13 = prod[PROD_HI:PROD_LO];
  assign prod_ext = ACCW'(prod_q13);
  assign unused_prod = ^{prod[2*DW-1:PROD_HI+1], prod[PROD_LO-1:0]};

  // stage 2: accumulate
  always_ff @(posedge clk_red) begin
    if (!rstn_red) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/one_unit_reduce.sv
// Reduction stage of the one-unit ICA datapath. Per accepted sample it
// rebuilds y = d1+d2+d3+d4 (the diagonal products z_i*w_i), forms z_i*y in
// four lanes, and after NSAMP samples outputs the average E{z_i*y} in Q13.
// Ports:
//   clk_red, rstn_red : clock, synchronous active-low reset
//   start             : begin a run (only in IDLE)
//   in_valid/in_ready : sample handshake for z1..z4, d1..d4
//   s1..s4            : averaged results, held until the next run completes
//   y_last            : projection of the most recently accepted sample
//   busy              : controller is not idle
//   sat_flag          : sticky clamp indicator (only with ONE_UNIT_REDUCE_SAT_EN)
//   done              : one-cycle pulse when s1..s4 update
// Build option: define ONE_UNIT_REDUCE_SAT_EN to saturate on narrowing and
// expose sat_flag; otherwise narrowing wraps.
module one_unit_reduce
  import ica_fx_pkg::*;
#(
  parameter int NSAMP      = 256,
  parameter int LOG2_NSAMP = 8,
  parameter int DW         = 26,
  parameter int ACCW       = 48
) (
  input  logic                 clk_red,
  input  logic                 rstn_red,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] z1,
  input  logic signed [DW-1:0] z2,
  input  logic signed [DW-1:0] z3,
  input  logic signed [DW-1:0] z4,
  input  logic signed [DW-1:0] d1,
  input  logic signed [DW-1:0] d2,
  input  logic signed [DW-1:0] d3,
  input  logic signed [DW-1:0] d4,
  output logic signed [DW-1:0] s1,
  output logic signed [DW-1:0] s2,
  output logic signed [DW-1:0] s3,
  output logic signed [DW-1:0] s4,
  output logic signed [DW-1:0] y_last,
  output logic                 busy,
`ifdef ONE_UNIT_REDUCE_SAT_EN
  output logic                 sat_flag,
`endif
  output logic                 done
);

`ifdef ONE_UNIT_REDUCE_SAT_EN
  localparam logic SAT_ON = 1'b1;
`else
  localparam logic SAT_ON = 1'b0;
`endif
  localparam int CNT_W = LOG2_NSAMP + 1;

  red_state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic start_acc;
  logic hs;

  logic signed [DW+1:0] y_sum;
  logic signed [DW-1:0] y_nar;

  logic                 vld_p0, vld_p1;
  logic signed [DW-1:0] y_p0;
  logic signed [DW-1:0] z_p0 [4];

  logic signed [ACCW-1:0] acc   [4];
  logic signed [DW-1:0]   s_nar [4];

  assign hs    = in_valid & in_ready;
  assign busy  = (state != IDLE);
  assign y_sum = (DW+2)'(d1) + (DW+2)'(d2) + (DW+2)'(d3) + (DW+2)'(d4);
  assign y_nar = narrow_dw(64'(y_sum), SAT_ON);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s_nar[i] = narrow_dw(64'(acc[i] >>> LOG2_NSAMP), SAT_ON);
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = ACC;
          start_acc = 1'b1;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == CNT_W'(NSAMP - 1))) state_nx = DRAIN;
      end
      // Both stages must be empty so the last product is in the accumulators.
      DRAIN: begin
        if (!vld_p0 && !vld_p1) state_nx = DIV;
      end
      DIV: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_red) begin
    if (!rstn_red) begin
      state  <= IDLE;
      cnt    <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      done   <= 1'b0;
      y_last <= '0;
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      s4     <= '0;
    end else begin
      state  <= state_nx;
      vld_p0 <= hs;
      vld_p1 <= vld_p0;
      done   <= (state == DIV);
      if (start_acc) begin
        cnt <= '0;
      end else if (hs) begin
        cnt <= cnt + 1'b1;
      end
      if (hs) y_last <= y_nar;
      // Dividing by NSAMP is an arithmetic shift since NSAMP is a power of two.
      if (state == DIV) begin
        s1 <= s_nar[0];
        s2 <= s_nar[1];
        s3 <= s_nar[2];
        s4 <= s_nar[3];
      end
    end
  end

  // stage 1: projection and sample registers
  always_ff @(posedge clk_red) begin
    if (hs) begin
      y_p0    <= y_nar;
      z_p0[0] <= z1;
      z_p0[1] <= z2;
      z_p0[2] <= z3;
      z_p0[3] <= z4;
    end
  end

`ifdef ONE_UNIT_REDUCE_SAT_EN
  logic s_ovf;
  always_comb begin
    s_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_ovf = s_ovf | ovf_dw(64'(acc[i] >>> LOG2_NSAMP));
    end
  end

  always_ff @(posedge clk_red) begin
    if (!rstn_red) begin
      sat_flag <= 1'b0;
    end else if (start_acc) begin
      sat_flag <= 1'b0;
    end else if ((hs && ovf_dw(64'(y_sum))) || ((state == DIV) && s_ovf)) begin
      sat_flag <= 1'b1;
    end
  end
`endif

  for (genvar g = 0; g < 4; g++) begin : g_lane
    one_unit_reduce_lane #(
      .DW   (DW),
      .ACCW (ACCW)
    ) u_lane (
      .clk_red  (clk_red),
      .rstn_red (rstn_red),
      .clr      (start_acc),
      .en       (vld_p0),
      .z        (z_p0[g]),
      .y        (y_p0),
      .acc      (acc[g])
    );
  end

endmodule

// File: tb/tb_one_unit_reduce.sv
// Directed bench for one_unit_reduce with NSAMP=4.
module tb_one_unit_reduce;

  localparam int DW = 26;

  logic                 clk_red = 1'b0;
  logic                 rstn_red;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] z1, z2, z3, z4, d1, d2, d3, d4;
  logic signed [DW-1:0] s1, s2, s3, s4, y_last;
  logic                 busy, done;
`ifdef ONE_UNIT_REDUCE_SAT_EN
  logic                 sat_flag;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_hs = 0;

  always #5 clk_red = ~clk_red;
  always @(posedge clk_red) cyc <= cyc + 1;

  one_unit_reduce #(
    .NSAMP      (4),
    .LOG2_NSAMP (2),
    .DW         (26),
    .ACCW       (48)
  ) dut (
    .clk_red  (clk_red),
    .rstn_red (rstn_red),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .z1 (z1), .z2 (z2), .z3 (z3), .z4 (z4),
    .d1 (d1), .d2 (d2), .d3 (d3), .d4 (d4),
    .s1 (s1), .s2 (s2), .s3 (s3), .s4 (s4),
    .y_last (y_last),
    .busy   (busy),
`ifdef ONE_UNIT_REDUCE_SAT_EN
    .sat_flag (sat_flag),
`endif
    .done   (done)
  );

  task automatic pulse_start();
    @(negedge clk_red);
    start = 1'b1;
    @(negedge clk_red);
    start = 1'b0;
  endtask

  // Present the same sample until n handshakes happen; gaps drops in_valid
  // every other cycle.
  task automatic feed(input logic signed [DW-1:0] zv [4], input logic signed [DW-1:0] dv [4],
                      input int n, input bit gaps, output int got);
    int  guard = 0;
    bit  ph = 1'b0;
    got = 0;
    while (got < n && guard < 100) begin
      @(negedge clk_red);
      guard++;
      z1 = zv[0]; z2 = zv[1]; z3 = zv[2]; z4 = zv[3];
      d1 = dv[0]; d2 = dv[1]; d3 = dv[2]; d4 = dv[3];
      in_valid = !(gaps && ph);
      ph = gaps ? !ph : 1'b0;
      if (in_valid && in_ready) begin
        got++;
        last_hs = cyc + 1;
      end
    end
    @(negedge clk_red);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit seen, output bit ir_hi);
    seen = 1'b0; ir_hi = 1'b0; lat = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_red);
      if (in_ready) ir_hi = 1'b1;
      if (done) begin
        seen = 1'b1;
        lat  = cyc - last_hs;
      end
    end
  endtask

  task automatic test_reset();
    rstn_red = 1'b0;
    repeat (3) @(negedge clk_red);
    total++; if (s1 !== 0 || s2 !== 0 || s3 !== 0 || s4 !== 0) begin bad++;
      $display("FAIL reset_s got %0d %0d %0d %0d want 0 0 0 0", s1, s2, s3, s4); end
    total++; if (y_last !== 0) begin bad++; $display("FAIL reset_y_last got %0d want 0", y_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rstn_red = 1'b1;
    @(negedge clk_red);
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] zv [4] = '{26'sd8192, 26'sd0, 26'sd0, 26'sd0};
    logic signed [DW-1:0] dv [4] = '{26'sd8192, 26'sd0, 26'sd0, 26'sd0};
    int got, lat; bit seen, ir_hi;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got %b want 1", busy); end
    feed(zv, dv, 4, 1'b0, got);
    total++; if (got !== 4) begin bad++; $display("FAIL basic_handshakes got %0d want 4", got); end
    wait_done(lat, seen, ir_hi);
    total++; if (!seen || lat !== 4) begin bad++; $display("FAIL basic_latency got %0d want 4", lat); end
    total++; if (y_last !== 26'sd8192) begin bad++; $display("FAIL basic_y_last got %0d want 8192", y_last); end
    total++; if (s1 !== 26'sd8192 || s2 !== 0 || s3 !== 0 || s4 !== 0) begin bad++;
      $display("FAIL basic_s got %0d %0d %0d %0d want 8192 0 0 0", s1, s2, s3, s4); end
    @(negedge clk_red);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got %b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_signed();
    logic signed [DW-1:0] zv [4] = '{-26'sd8192, 26'sd4096, 26'sd0, 26'sd0};
    logic signed [DW-1:0] dv [4] = '{26'sd4096, 26'sd4096, 26'sd0, 26'sd0};
    int got, lat; bit seen, ir_hi;
    pulse_start();
    feed(zv, dv, 4, 1'b0, got);
    wait_done(lat, seen, ir_hi);
    total++; if (!seen || lat !== 4) begin bad++; $display("FAIL signed_latency got %0d want 4", lat); end
    total++; if (y_last !== 26'sd8192) begin bad++; $display("FAIL signed_y_last got %0d want 8192", y_last); end
    total++; if (s1 !== -26'sd8192 || s2 !== 26'sd4096 || s3 !== 0 || s4 !== 0) begin bad++;
      $display("FAIL signed_s got %0d %0d %0d %0d want -8192 4096 0 0", s1, s2, s3, s4); end
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] zv [4] = '{26'sd0, 26'sd0, 26'sd8192, 26'sd0};
    logic signed [DW-1:0] dv [4] = '{26'sd0, 26'sd0, 26'sd0, 26'sd8192};
    int got, lat; bit seen, ir_hi;
    @(negedge clk_red);
    in_valid = 1'b1;
    @(negedge clk_red);
    total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL idle_valid got ready=%b busy=%b want 0 0", in_ready, busy); end
    in_valid = 1'b0;
    pulse_start();
    feed(zv, dv, 4, 1'b1, got);
    wait_done(lat, seen, ir_hi);
    total++; if (!seen || lat !== 4) begin bad++; $display("FAIL bp_latency got %0d want 4", lat); end
    total++; if (ir_hi !== 1'b0) begin bad++; $display("FAIL bp_ready_in_drain got %b want 0", ir_hi); end
    total++; if (s1 !== 0 || s2 !== 0 || s3 !== 26'sd8192 || s4 !== 0) begin bad++;
      $display("FAIL bp_s got %0d %0d %0d %0d want 0 0 8192 0", s1, s2, s3, s4); end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] zv [4] = '{26'sd8192, 26'sd0, 26'sd0, 26'sd0};
    logic signed [DW-1:0] dv [4] = '{26'sd33554431, 26'sd33554431, 26'sd33554431, 26'sd33554431};
    int got, lat; bit seen, ir_hi;
    pulse_start();
    feed(zv, dv, 4, 1'b0, got);
    wait_done(lat, seen, ir_hi);
    total++; if (!seen || lat !== 4) begin bad++; $display("FAIL sat_latency got %0d want 4", lat); end
`ifdef ONE_UNIT_REDUCE_SAT_EN
    total++; if (y_last !== 26'sd33554431) begin bad++; $display("FAIL sat_y_last got %0d want 33554431", y_last); end
    total++; if (s1 !== 26'sd33554431) begin bad++; $display("FAIL sat_s1 got %0d want 33554431", s1); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag got %b want 1", sat_flag); end
`else
    total++; if (y_last !== -26'sd4) begin bad++; $display("FAIL wrap_y_last got %0d want -4", y_last); end
    total++; if (s1 !== -26'sd4) begin bad++; $display("FAIL wrap_s1 got %0d want -4", s1); end
`endif
  endtask

  task automatic test_start_ignore();
    logic signed [DW-1:0] zv [4] = '{26'sd0, 26'sd8192, 26'sd0, 26'sd0};
    logic signed [DW-1:0] dv [4] = '{26'sd8192, 26'sd0, 26'sd0, 26'sd0};
    int got, lat; bit seen, ir_hi;
    pulse_start();
`ifdef ONE_UNIT_REDUCE_SAT_EN
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_flag_clear got %b want 0", sat_flag); end
`endif
    feed(zv, dv, 2, 1'b0, got);
    pulse_start();
    feed(zv, dv, 2, 1'b0, got);
    wait_done(lat, seen, ir_hi);
    total++; if (!seen || lat !== 4) begin bad++; $display("FAIL ignore_latency got %0d want 4", lat); end
    total++; if (s1 !== 0 || s2 !== 26'sd8192) begin bad++;
      $display("FAIL ignore_s got %0d %0d want 0 8192", s1, s2); end
  endtask

  task automatic test_abort();
    logic signed [DW-1:0] zv [4] = '{26'sd8192, 26'sd8192, 26'sd8192, 26'sd8192};
    logic signed [DW-1:0] dv [4] = '{26'sd8192, 26'sd0, 26'sd0, 26'sd0};
    int got; bit saw_done = 1'b0;
    pulse_start();
    feed(zv, dv, 1, 1'b0, got);
    @(negedge clk_red);
    in_valid = 1'b1;
    rstn_red = 1'b0;
    @(negedge clk_red);
    rstn_red = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_red);
      if (done) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_done got %b want 0", saw_done); end
    total++; if (s1 !== 0 || s2 !== 0 || s3 !== 0 || s4 !== 0 || y_last !== 0) begin bad++;
      $display("FAIL abort_outputs got %0d %0d %0d %0d y=%0d want all 0", s1, s2, s3, s4, y_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", busy); end
  endtask

  initial begin
    rstn_red = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    z1 = '0; z2 = '0; z3 = '0; z4 = '0;
    d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_saturation();
    test_start_ignore();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
